// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
//   Byte stream from the UART receiver to its consumer.
//
//   Signals
//     data      [7:0]  received byte, stable while valid is high
//     valid            data holds a byte that has not been consumed yet
//     ready            consumer accept; a byte moves on valid & ready
//     frame_err        one-cycle pulse: stop bit sampled low
//     overrun          one-cycle pulse: a completed byte was dropped
//
//   Modports
//     master  the receiver (drives data/valid/frame_err/overrun)
//     slave   the consumer (drives ready)
// ---------------------------------------------------------------------------
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        output ready
    );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver with a one-entry valid/ready output register.
//   The line is oversampled by a down-counter: a falling edge starts a
//   half-bit countdown, the start bit is re-checked at its centre, then
//   each data bit and the stop bit are sampled one bit period apart.
//   Reception never stalls on backpressure; a byte completing while the
//   previous one is still unconsumed is dropped and flagged as overrun.
//
//   Parameters
//     CLK_HZ   clock frequency in Hz
//     BAUD     line bit rate
//
//   Ports
//     clk      single clock, rising edge
//     rst_n    asynchronous active-low reset
//     rx       asynchronous serial line, idle high, LSB first
//     bus      uart_rx_if.master: data, valid, ready, frame_err, overrun
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 921_600
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master bus
);

    // Clocks per bit, rounded to nearest; HALF positions the first sample
    // in the middle of the start bit.
    localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_START = 3'd1,
        R_DATA  = 3'd2,
        R_STOP  = 3'd3,
        R_WAIT  = 3'd4
    } state_e;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic          sync1_q;
    logic          sync2_q;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shreg_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          frame_err_q;
    logic          overrun_q;

    // Next-state of the output register
    logic [7:0]    data_d;
    logic          valid_d;
    logic          overrun_d;

    logic          rxs;
    logic          cnt_zero;
    logic          stop_ok;

    assign rxs      = sync2_q;
    assign cnt_zero = (cnt_q == '0);

    // Stop bit sampled high: the byte in shreg_q is complete and good.
    assign stop_ok  = (state_q == R_STOP) && cnt_zero && rxs;

    // -----------------------------------------------------------------------
    // Two-flop synchronizer; both flops reset to the idle (high) level so a
    // reset release never looks like a start edge unless rx really is low.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Output register / delivery.
    // A consumed byte frees the slot in the same cycle, so a new byte may be
    // loaded on the edge where the old one is accepted. If the slot is still
    // held (valid & !ready) the new byte is dropped and the held byte stays.
    // -----------------------------------------------------------------------
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end

        if (stop_ok) begin
            if (!valid_q || bus.ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Bit FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= R_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= 1'b0;

            case (state_q)
                R_IDLE: begin
                    if (!rxs) begin
                        state_q <= R_START;
                        cnt_q   <= CNT_HALF;
                    end
                end

                // Centre of the start bit: a high line here means the
                // falling edge was a glitch, so drop back silently.
                R_START: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!rxs) begin
                        state_q   <= R_DATA;
                        cnt_q     <= CNT_FULL;
                        bit_idx_q <= 3'd0;
                    end else begin
                        state_q <= R_IDLE;
                    end
                end

                // LSB arrives first, so shifting right leaves bit 0 in
                // shreg_q[0] after the eighth sample.
                R_DATA: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shreg_q <= {rxs, shreg_q[7:1]};
                        cnt_q   <= CNT_FULL;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= R_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end

                R_STOP: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (rxs) begin
                        state_q <= R_IDLE;
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= R_WAIT;
                    end
                end

                // Park here while the line is held low (break) so that a
                // long low level reports only one framing error.
                R_WAIT: begin
                    if (rxs) begin
                        state_q <= R_IDLE;
                    end
                end

                default: begin
                    state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Directed and randomized stimulus for uart_rx at default parameters
//   (DIV = 54 clocks per bit). A line-level transmitter drives rx; a
//   monitor records accepted bytes and error pulses, and the expected
//   outcome of each step is derived from the bytes sent and the protocol
//   rules (one slot, drop-on-full, one error per bad stop bit).
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BITC = 54;   // nominal clocks per bit at default CLK_HZ/BAUD
    localparam int LAT  = 516;  // 9.5*DIV + 3

    logic clk;
    logic rst_n;
    logic rx;

    uart_rx_if u_if ();

    uart_rx #(
        .CLK_HZ (50_000_000),
        .BAUD   (921_600)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // -----------------------------------------------------------------------
    // Monitor: counts and captures, sampled on the falling edge
    // -----------------------------------------------------------------------
    int         cyc        = 0;
    int         t_fall     = 0;
    int         rise_cyc   = 0;
    int         n_xfer     = 0;
    int         n_vhigh    = 0;
    int         n_ferr     = 0;
    int         n_ovr      = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.valid === 1'b1 && u_if.ready === 1'b1) begin
            got_q.push_back(u_if.data);
            n_xfer++;
        end
        if (u_if.valid === 1'b1) n_vhigh++;
        if (u_if.valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
        prev_valid = u_if.valid;
        if (u_if.frame_err === 1'b1) n_ferr++;
        if (u_if.overrun === 1'b1) n_ovr++;
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 8N1 frame, LSB first, bc clocks per bit; rx is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int bc);
        t_fall = cyc;
        rx = 1'b0;
        wait_cyc(bc);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(bc);
        end
        rx = stop;
        wait_cyc(bc);
    endtask

    // -----------------------------------------------------------------------
    // Directed and randomized sequence
    // -----------------------------------------------------------------------
    int         x0, f0, o0, v0, g0, lat;
    logic [7:0] exp_q[$];
    logic [7:0] rb;
    int         rbc;

    initial begin
        rst_n      = 1'b0;
        rx         = 1'b1;
        u_if.ready = 1'b1;
        wait_cyc(3);

        // Reset state
        check("reset_valid",     32'(u_if.valid),     32'd0);
        check("reset_data",      32'(u_if.data),      32'd0);
        check("reset_frame_err", 32'(u_if.frame_err), 32'd0);
        check("reset_overrun",   32'(u_if.overrun),   32'd0);
        rst_n = 1'b1;
        wait_cyc(2 * BITC);

        // Single byte with ready high
        x0 = n_xfer; f0 = n_ferr; o0 = n_ovr; v0 = n_vhigh; g0 = got_q.size();
        send_frame(8'hA5, 1'b1, BITC);
        lat = rise_cyc - t_fall;
        wait_cyc(2 * BITC);
        check("a5_latency",   32'(lat), 32'(LAT));
        check("a5_xfers",     32'(n_xfer - x0), 32'd1);
        check("a5_data",      32'(got_q[g0]), 32'hA5);
        check("a5_valid_len", 32'(n_vhigh - v0), 32'd1);
        check("a5_frame_err", 32'(n_ferr - f0), 32'd0);
        check("a5_overrun",   32'(n_ovr - o0), 32'd0);

        // Backpressure: second byte dropped, first one held
        u_if.ready = 1'b0;
        x0 = n_xfer; f0 = n_ferr; o0 = n_ovr; g0 = got_q.size();
        send_frame(8'h3C, 1'b1, BITC);
        send_frame(8'h7E, 1'b1, BITC);
        wait_cyc(20);
        check("bp_valid_held", 32'(u_if.valid), 32'd1);
        check("bp_data_held",  32'(u_if.data),  32'h3C);
        check("bp_overrun",    32'(n_ovr - o0), 32'd1);
        check("bp_no_xfer",    32'(n_xfer - x0), 32'd0);
        u_if.ready = 1'b1;
        wait_cyc(2);
        check("bp_valid_clear", 32'(u_if.valid), 32'd0);
        check("bp_data_after",  32'(u_if.data),  32'h3C);
        check("bp_xfer",        32'(n_xfer - x0), 32'd1);
        check("bp_xfer_data",   32'(got_q[g0]), 32'h3C);
        check("bp_frame_err",   32'(n_ferr - f0), 32'd0);

        // Bad stop bit followed by a 30-bit break, then a good byte
        x0 = n_xfer; f0 = n_ferr; o0 = n_ovr; g0 = got_q.size();
        send_frame(8'h55, 1'b0, BITC);
        wait_cyc(30 * BITC);
        check("brk_no_valid", 32'(n_xfer - x0), 32'd0);
        rx = 1'b1;
        wait_cyc(2 * BITC);
        send_frame(8'h12, 1'b1, BITC);
        wait_cyc(20);
        check("brk_frame_err", 32'(n_ferr - f0), 32'd1);
        check("brk_xfers",     32'(n_xfer - x0), 32'd1);
        check("brk_data",      32'(got_q[g0]), 32'h12);
        check("brk_overrun",   32'(n_ovr - o0), 32'd0);

        // Short glitch on idle line, then a byte to show the receiver recovered
        x0 = n_xfer; f0 = n_ferr; g0 = got_q.size();
        rx = 1'b0;
        wait_cyc(10);
        rx = 1'b1;
        wait_cyc(100);
        check("glitch_no_xfer", 32'(n_xfer - x0), 32'd0);
        check("glitch_no_ferr", 32'(n_ferr - f0), 32'd0);
        check("glitch_valid",   32'(u_if.valid), 32'd0);
        send_frame(8'h5A, 1'b1, BITC);
        wait_cyc(20);
        check("glitch_after_data", 32'(got_q[g0]), 32'h5A);

        // Reset in the middle of bit 4 of 0xFF
        x0 = n_xfer; f0 = n_ferr; g0 = got_q.size();
        rx = 1'b0;
        wait_cyc(BITC);
        rx = 1'b1;
        wait_cyc(4 * BITC + BITC / 2);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(u_if.valid), 32'd0);
        check("midrst_data",  32'(u_if.data),  32'd0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(12 * BITC);
        send_frame(8'h81, 1'b1, BITC);
        wait_cyc(20);
        check("midrst_xfers", 32'(n_xfer - x0), 32'd1);
        check("midrst_data81", 32'(got_q[g0]), 32'h81);
        check("midrst_ferr",  32'(n_ferr - f0), 32'd0);

        // Back-to-back 0x00 / 0xFF at about +2% and -2% bit-time error
        x0 = n_xfer; f0 = n_ferr; o0 = n_ovr; g0 = got_q.size();
        send_frame(8'h00, 1'b1, BITC + 1);
        send_frame(8'hFF, 1'b1, BITC + 1);
        send_frame(8'h00, 1'b1, BITC - 1);
        send_frame(8'hFF, 1'b1, BITC - 1);
        wait_cyc(20);
        check("ppm_xfers", 32'(n_xfer - x0), 32'd4);
        check("ppm_b0",    32'(got_q[g0]),     32'h00);
        check("ppm_b1",    32'(got_q[g0 + 1]), 32'hFF);
        check("ppm_b2",    32'(got_q[g0 + 2]), 32'h00);
        check("ppm_b3",    32'(got_q[g0 + 3]), 32'hFF);
        check("ppm_errs",  32'((n_ferr - f0) + (n_ovr - o0)), 32'd0);

        // Random bytes, random bit-time error and random gaps, ready high:
        // every frame must come out once, in order, with no error pulses.
        x0 = n_xfer; f0 = n_ferr; o0 = n_ovr; g0 = got_q.size();
        exp_q.delete();
        for (int k = 0; k < 24; k++) begin
            rb  = 8'($urandom_range(0, 255));
            rbc = BITC - 1 + int'($urandom_range(0, 2));
            exp_q.push_back(rb);
            send_frame(rb, 1'b1, rbc);
            wait_cyc(int'($urandom_range(0, 3)) * BITC + int'($urandom_range(0, 20)));
        end
        wait_cyc(40);
        check("rand_xfers", 32'(n_xfer - x0), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (g0 + k < got_q.size())
                check($sformatf("rand_byte%0d", k), 32'(got_q[g0 + k]), 32'(exp_q[k]));
            else
                check($sformatf("rand_byte%0d_missing", k), 32'hFFFF_FFFF, 32'(exp_q[k]));
        end
        check("rand_ferr", 32'(n_ferr - f0), 32'd0);
        check("rand_ovr",  32'(n_ovr - o0),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, SHALL be the clock frequency in Hz.
REQ-002 Parameter BAUD, default 921_600, SHALL be the line bit rate.
REQ-003 clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 rx  input  1  SHALL be the asynchronous serial line: idle high, 8N1, LSB first.
REQ-006 data  output  8  SHALL be the received byte, stable while valid=1.
REQ-007 valid  output  1  SHALL indicate that data holds an unconsumed byte.
REQ-008 ready  input  1  SHALL be the consumer accept; a byte transfers on a cycle with valid=1 and ready=1.
REQ-009 frame_err  output  1  SHALL be a one-cycle pulse when the stop bit samples low.
REQ-010 overrun  output  1  SHALL be a one-cycle pulse when a completed byte is dropped.

Function
REQ-011 DIV SHALL equal (CLK_HZ + BAUD/2) / BAUD, integer division (54 at defaults); HALF SHALL equal DIV/2 (27).
REQ-012 The bit counter SHALL be $clog2(DIV+1) bits wide, load DIV-1 or HALF-1, and count down to 0 without wrapping.
REQ-013 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); only the synchronized value rxs SHALL be used.
REQ-014 States SHALL be R_IDLE, R_START, R_DATA, R_STOP, R_WAIT.
REQ-015 R_IDLE: when rxs=0, go to R_START and load cnt=HALF-1.
REQ-016 R_START: at cnt=0, if rxs=0 go to R_DATA with cnt=DIV-1 and bit_idx=0; if rxs=1 (glitch) return to R_IDLE with no output activity.
REQ-017 R_DATA: at cnt=0, shift rxs into shreg MSB (shift right) and reload cnt=DIV-1; after the sample with bit_idx=7, go to R_STOP, else increment bit_idx.
REQ-018 R_STOP: at cnt=0, if rxs=1, deliver shreg per REQ-020 and go to R_IDLE; if rxs=0, pulse frame_err, discard the byte and go to R_WAIT.
REQ-019 R_WAIT: remain until rxs=1, then go to R_IDLE; a held-low line (break) SHALL produce exactly one frame_err.
REQ-020 Delivery: if valid=0, or valid=1 and ready=1 in the same cycle, load data=shreg and set valid=1 on the next edge; if valid=1 and ready=0, keep data, keep valid=1 and pulse overrun.
REQ-021 valid SHALL clear on the edge after valid=1 and ready=1 unless REQ-020 reloads it on that edge; ready has no effect while valid=0.
REQ-022 data and valid SHALL be held unchanged while valid=1 and ready=0.
REQ-023 Latency: valid SHALL rise on the edge following the stop-bit sample, i.e. about 9.5*DIV + 3 cycles after the rx falling edge.
REQ-024 Reception SHALL continue regardless of ready; backpressure never stalls the bit FSM.
REQ-025 Illegal state encodings SHALL return to R_IDLE on the next edge.

Reset
REQ-026 When rst_n=0: state=R_IDLE, cnt=0, bit_idx=0, shreg=0, data=0, valid=0, frame_err=0, overrun=0, both synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL wait for a new falling edge and SHALL NOT emit a partial byte.
REQ-028 A line that is low at reset release SHALL be treated as a start edge; the resulting frame is valid only if it passes REQ-016 to REQ-018.

Verification
REQ-029 Drive 0xA5 at DIV=54, 8N1, ready=1 -> valid=1 for exactly one cycle with data=0xA5; frame_err=0, overrun=0.
REQ-030 Send 0x3C, then 0x7E, with ready=0 throughout -> data stays 0x3C with valid=1, one overrun pulse at the second stop sample; then raise ready -> valid clears and data is still 0x3C.
REQ-031 Send 0x55 with the stop bit driven low, then hold rx low for 30 bit times -> exactly one frame_err pulse, no valid; after rx rises, 0x12 is received correctly.
REQ-032 Drive a 10-cycle low glitch on an idle line -> return to R_IDLE from R_START; no valid, no frame_err.
REQ-033 Assert rst_n low during bit 4 of 0xFF, then release and send 0x81 -> only 0x81 is delivered.
REQ-034 Transmit back-to-back bytes 0x00 and 0xFF at +/-2% baud error with ready tied high -> both bytes received with no error pulses.
